// File: rtl/five_tuple_ingress_arbiter.sv
// Packet-granular round-robin arbiter feeding one five_tuple_extractor from NUM_PORTS AXI-Stream
// sources, with a stall watchdog that aborts and drains packets whose source goes quiet mid-packet.
module five_tuple_ingress_arbiter #(
    parameter  int NUM_PORTS      = 4,
    parameter  int AXI_DATA_WIDTH = 32,
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int ID_W           = ($clog2(NUM_PORTS) > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int KEEP_W         = AXI_DATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS*AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS*KEEP_W-1:0]   s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]          s_axis_tlast,
    input  logic [NUM_PORTS-1:0]          s_axis_tvalid,
    output logic [NUM_PORTS-1:0]          s_axis_tready,
    output logic [AXI_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [KEEP_W-1:0]             m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [ID_W-1:0]               m_axis_tid,
    output logic                          m_axis_tuser,
    output logic                          busy,
    output logic                          timeout_pulse,
    output logic [ID_W-1:0]               timeout_port,
    output logic [15:0]                   abort_count
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, PASS, ABORT, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [ID_W-1:0]   next_ptr;
    logic [ID_W-1:0]   arb_idx;
    logic [ID_W-1:0]   cand;
    logic              arb_found;

    logic [AXI_DATA_WIDTH-1:0] port_data [NUM_PORTS];
    logic [KEEP_W-1:0]         port_keep [NUM_PORTS];

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_split
        assign port_data[k] = s_axis_tdata[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        assign port_keep[k] = s_axis_tkeep[k*KEEP_W +: KEEP_W];
    end

    logic g_valid, g_last;
    assign g_valid  = s_axis_tvalid[grant_q];
    assign g_last   = s_axis_tlast[grant_q];
    assign next_ptr = (grant_q == ID_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
    assign busy     = (state_q != IDLE);

    // Cyclic search for the first requester at or after rr_ptr.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = ID_W'((int'(rr_ptr_q) + i) % NUM_PORTS);
            if (!arb_found && s_axis_tvalid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        idle_cnt_d    = idle_cnt_q;
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tid    = '0;
        m_axis_tuser  = 1'b0;
        timeout_pulse = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d    = arb_idx;
                    idle_cnt_d = '0;
                    state_d    = PASS;
                end
            end
            PASS: begin
                m_axis_tdata           = port_data[grant_q];
                m_axis_tkeep           = port_keep[grant_q];
                m_axis_tlast           = g_last;
                m_axis_tvalid          = g_valid;
                m_axis_tid             = grant_q;
                s_axis_tready[grant_q] = m_axis_tready;
                if (g_valid && m_axis_tready && g_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end else if (TIMEOUT_CYCLES > 0) begin
                    // Only source silence counts; downstream backpressure keeps tvalid high.
                    if (g_valid) begin
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d       = ABORT;
                        timeout_pulse = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            ABORT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = 1'b1;
                m_axis_tid    = grant_q;
                if (m_axis_tready) state_d = DRAIN;
            end
            DRAIN: begin
                s_axis_tready[grant_q] = 1'b1;
                if (g_valid && g_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            idle_cnt_q   <= '0;
            timeout_port <= '0;
            abort_count  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            idle_cnt_q <= idle_cnt_d;
            if (timeout_pulse) begin
                timeout_port <= grant_q;
                if (abort_count != 16'hFFFF) abort_count <= abort_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_five_tuple_ingress_arbiter.sv
// Self-checking bench: per-port packet queues drive the sources, and a round-robin packet model
// predicts the exact output beat stream, tid and abort behaviour.
module tb_five_tuple_ingress_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int TO = 256;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NP*DW-1:0] s_tdata;
    logic [NP*KW-1:0] s_tkeep;
    logic [NP-1:0]    s_tlast, s_tvalid, s_tready;
    logic [DW-1:0]    m_tdata;
    logic [KW-1:0]    m_tkeep;
    logic             m_tlast, m_tvalid, m_tready, m_tuser;
    logic [IW-1:0]    m_tid, timeout_port;
    logic             busy, timeout_pulse;
    logic [15:0]      abort_count;

    five_tuple_ingress_arbiter #(
        .NUM_PORTS(NP), .AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tid(m_tid), .m_axis_tuser(m_tuser),
        .busy(busy), .timeout_pulse(timeout_pulse),
        .timeout_port(timeout_port), .abort_count(abort_count)
    );

    typedef struct packed {logic [DW-1:0] data; logic [KW-1:0] keep; logic last;} beat_t;
    typedef struct packed {logic [IW-1:0] tid; logic tuser; beat_t b;} obeat_t;

    beat_t  src_q [NP][$];
    beat_t  mq    [NP][$];
    obeat_t exp_q [$];
    int stall [NP];
    int last_acc_cyc [NP];
    int model_rr, cyc, n_assert, n_fail;
    int ready_mode, last_end, out_cnt, pulse_cnt, pulse_cyc, abort_pres_cyc;
    bit rand_stall, gap_check, in_pkt;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void load_pkt(int p, int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = $urandom;
            b.keep = KW'($urandom);
            b.last = (i == len - 1);
            src_q[p].push_back(b);
            mq[p].push_back(b);
        end
    endfunction

    // Reference: serve whole packets from non-empty ports in round-robin order from model_rr.
    function automatic void predict();
        int p;
        bit found;
        beat_t b;
        while (1) begin
            found = 1'b0;
            p = 0;
            for (int i = 0; i < NP; i++)
                if (!found && mq[(model_rr + i) % NP].size() > 0) begin
                    found = 1'b1;
                    p = (model_rr + i) % NP;
                end
            if (!found) break;
            do begin
                b = mq[p].pop_front();
                exp_q.push_back(obeat_t'{tid: IW'(p), tuser: 1'b0, b: b});
            end while (!b.last);
            model_rr = (p + 1) % NP;
        end
    endfunction

    function automatic int pending();
        int n = exp_q.size();
        for (int p = 0; p < NP; p++) n += src_q[p].size();
        return n;
    endfunction

    function automatic void clear_all();
        exp_q.delete();
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            mq[p].delete();
            stall[p] = 0;
        end
        model_rr = 0;
        in_pkt = 1'b0;
        last_end = 0;
    endfunction

    task automatic check_reset_outputs();
        check("reset_ctrl", {s_tready, m_tvalid, m_tuser, busy, m_tlast, m_tid,
                             timeout_pulse, timeout_port, abort_count}, 0);
        check("reset_data", {m_tkeep, m_tdata}, 0);
    endtask

    // One cycle: drive at posedge+1, sample and score at posedge+4.
    task automatic step();
        logic [NP-1:0] drv_v;
        beat_t b;
        obeat_t e;
        @(posedge clk);
        cyc++;
        #1;
        for (int p = 0; p < NP; p++) begin
            if (stall[p] > 0) begin
                drv_v[p] = 1'b0;
                stall[p]--;
            end else begin
                drv_v[p] = (src_q[p].size() > 0);
            end
            if (drv_v[p]) begin
                b = src_q[p][0];
                s_tdata[p*DW +: DW] = b.data;
                s_tkeep[p*KW +: KW] = b.keep;
                s_tlast[p]          = b.last;
            end else begin
                s_tdata[p*DW +: DW] = $urandom;
                s_tkeep[p*KW +: KW] = KW'($urandom);
                s_tlast[p]          = 1'($urandom);
            end
        end
        s_tvalid = drv_v;
        m_tready = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 3) != 0);
        #3;
        check("ready_onehot0", 64'($onehot0(s_tready)), 1);
        if (timeout_pulse) begin
            pulse_cnt++;
            pulse_cyc = cyc;
        end
        if (m_tvalid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {m_tid, m_tuser, m_tdata}, 64'hDEAD);
            end else begin
                e = exp_q[0];
                check("beat", {m_tid, m_tuser, m_tdata, m_tkeep, m_tlast}, e);
                check("s_ready", s_tready, (!e.tuser && m_tready) ? (1 << e.tid) : 0);
                if (e.tuser && abort_pres_cyc < 0) abort_pres_cyc = cyc;
                if (!in_pkt) begin
                    if (gap_check && last_end > 0) check("bubble_gap", cyc - last_end, 2);
                    in_pkt = 1'b1;
                end
                if (m_tready) begin
                    void'(exp_q.pop_front());
                    out_cnt++;
                    if (e.b.last) begin
                        in_pkt = 1'b0;
                        last_end = cyc;
                    end
                end
            end
        end
        for (int p = 0; p < NP; p++)
            if (drv_v[p] && s_tready[p]) begin
                b = src_q[p].pop_front();
                last_acc_cyc[p] = cyc;
                if (!b.last && rand_stall) stall[p] = $urandom_range(0, 3);
            end
    endtask

    task automatic run_until_done(int bound);
        int n = 0;
        while (pending() > 0 && n < bound) begin
            step();
            n++;
        end
        check("drain_done", pending(), 0);
    endtask

    task automatic run_until_out(int target, int bound);
        int n = 0;
        while (out_cnt < target && n < bound) begin
            step();
            n++;
        end
        check("reach_out_cnt", out_cnt, target);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_tvalid = '0;
        m_tready = 1'b0;
        clear_all();
        @(posedge clk);
        #4;
        check_reset_outputs();
        @(posedge clk);
        #4;
        rst_n = 1'b1;
    endtask

    initial begin
        int a1;
        n_assert = 0; n_fail = 0; cyc = 0;
        ready_mode = 1; rand_stall = 1'b0; gap_check = 1'b0;
        pulse_cnt = 0; pulse_cyc = 0; abort_pres_cyc = -1; out_cnt = 0;
        s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tvalid = '0; m_tready = 1'b0;
        for (int p = 0; p < NP; p++) last_acc_cyc[p] = 0;

        // Port 1, 5 beats: one-cycle arbitration latency, tid=1, then rr_ptr=2 (port 2 beats port 1).
        do_reset();
        load_pkt(1, 5);
        predict();
        step();
        check("idle_before_grant", m_tvalid, 0);
        step();
        check("arb_latency", {m_tvalid, m_tid}, {1'b1, 2'd1});
        run_until_done(100);
        load_pkt(1, 1);
        load_pkt(2, 1);
        predict();
        run_until_done(100);

        // Ports 0 and 2 from reset, 3-beat packets, one bubble between them.
        do_reset();
        gap_check = 1'b1;
        load_pkt(0, 3);
        load_pkt(2, 3);
        predict();
        run_until_done(100);

        // All four ports, 2-beat packets: tid 0,0,1,1,2,2,3,3,0,0.
        do_reset();
        for (int p = 0; p < NP; p++) load_pkt(p, 2);
        load_pkt(0, 2);
        predict();
        run_until_done(200);
        gap_check = 1'b0;

        // Port 3 under 300 cycles of downstream backpressure: no abort.
        do_reset();
        pulse_cnt = 0; out_cnt = 0;
        load_pkt(3, 4);
        predict();
        run_until_out(2, 20);
        ready_mode = 0;
        repeat (300) step();
        check("no_abort_backpressure", {pulse_cnt[15:0], abort_count}, 0);
        ready_mode = 1;
        run_until_done(50);

        // Port 2 stalls 256 cycles after 2 beats: abort beat, drain of 3 late beats, rr_ptr=3.
        pulse_cnt = 0; abort_pres_cyc = -1;
        load_pkt(2, 5);
        mq[2].delete();
        exp_q.push_back(obeat_t'{tid: 2'd2, tuser: 1'b0, b: src_q[2][0]});
        exp_q.push_back(obeat_t'{tid: 2'd2, tuser: 1'b0, b: src_q[2][1]});
        exp_q.push_back(obeat_t'{tid: 2'd2, tuser: 1'b1, b: beat_t'{data: '0, keep: '0, last: 1'b1}});
        model_rr = 3;
        begin
            int n = 0;
            while (src_q[2].size() > 3 && n < 20) begin
                step();
                n++;
            end
        end
        a1 = last_acc_cyc[2];
        stall[2] = TO;
        run_until_done(400);
        check("abort_pulse_count", pulse_cnt, 1);
        check("abort_timing", pulse_cyc - a1, TO);
        check("abort_beat_next", abort_pres_cyc - pulse_cyc, 1);
        check("timeout_port_count", {timeout_port, abort_count}, {2'd2, 16'd1});
        load_pkt(0, 1);
        load_pkt(3, 1);
        predict();
        run_until_done(50);

        // tlast arriving exactly when the idle count would hit threshold completes normally.
        pulse_cnt = 0; out_cnt = 0;
        load_pkt(1, 2);
        predict();
        run_until_out(1, 20);
        stall[1] = TO - 1;
        run_until_done(400);
        check("tlast_at_threshold", {pulse_cnt[15:0], abort_count}, {16'd0, 16'd1});

        // Asynchronous reset mid-packet on port 1, then fresh arbitration from rr_ptr=0.
        out_cnt = 0;
        load_pkt(1, 4);
        predict();
        run_until_out(2, 20);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        clear_all();
        s_tvalid = '0;
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        load_pkt(1, 1);
        load_pkt(3, 1);
        load_pkt(0, 1);
        predict();
        run_until_done(50);

        // Randomised traffic: random lengths, mid-packet stalls and downstream backpressure.
        do_reset();
        rand_stall = 1'b1;
        ready_mode = 2;
        pulse_cnt = 0;
        for (int k = 0; k < 6; k++)
            for (int p = 0; p < NP; p++) load_pkt(p, $urandom_range(1, 4));
        predict();
        run_until_done(3000);
        check("random_no_abort", pulse_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
